// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// instr_encoder : encodes RV32I instruction requests into instruction-memory writes
// Revision 1.0
// ============================================================================
module instr_encoder (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] base_addr_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  kind_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic        imem_we_o,
    output logic [31:0] imem_addr_o,
    output logic [31:0] imem_wdata_o,
    input  logic        imem_ack_i,
    output logic [15:0] count_o,
    output logic        err_o
);

    localparam logic [2:0] KIND_R      = 3'd0;
    localparam logic [2:0] KIND_I      = 3'd1;
    localparam logic [2:0] KIND_LOAD   = 3'd2;
    localparam logic [2:0] KIND_STORE  = 3'd3;
    localparam logic [2:0] KIND_BRANCH = 3'd4;
    localparam logic [2:0] KIND_JAL    = 3'd5;
    localparam logic [2:0] KIND_JALR   = 3'd6;
    localparam logic [2:0] KIND_LUI    = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] enc_word;
    logic        illegal;
    logic        fits12;
    logic        fits13;
    logic        fits21;

    // A signed N-bit field fits when every bit above N-1 copies bit N-1.
    assign fits12 = (imm_i[31:11] == {21{imm_i[11]}});
    assign fits13 = (imm_i[31:12] == {20{imm_i[12]}});
    assign fits21 = (imm_i[31:20] == {12{imm_i[20]}});

    always_comb begin
        enc_word = 32'd0;
        illegal  = 1'b0;
        case (kind_i)
            KIND_R: begin
                enc_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, 7'b0110011};
            end
            KIND_I: begin
                enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, 7'b0010011};
                illegal  = !fits12;
            end
            KIND_LOAD: begin
                enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, 7'b0000011};
                illegal  = !fits12;
            end
            KIND_STORE: begin
                enc_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], 7'b0100011};
                illegal  = !fits12;
            end
            KIND_BRANCH: begin
                enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:1], imm_i[11], 7'b1100011};
                illegal  = !fits13 || imm_i[0];
            end
            KIND_JAL: begin
                enc_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, 7'b1101111};
                illegal  = !fits21 || imm_i[0];
            end
            KIND_JALR: begin
                enc_word = {imm_i[11:0], rs1_i, 3'b000, rd_i, 7'b1100111};
                illegal  = !fits12;
            end
            KIND_LUI: begin
                enc_word = {imm_i[31:12], rd_i, 7'b0110111};
            end
            default: begin
                enc_word = 32'd0;
                illegal  = 1'b0;
            end
        endcase
    end

    // start_i outranks any handshake or ack in the same cycle, discarding a pending write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            req_ready_o  <= 1'b0;
            imem_we_o    <= 1'b0;
            imem_addr_o  <= 32'd0;
            imem_wdata_o <= 32'd0;
            count_o      <= 16'd0;
            err_o        <= 1'b0;
        end else if (start_i) begin
            state       <= READY;
            req_ready_o <= 1'b1;
            imem_we_o   <= 1'b0;
            imem_addr_o <= base_addr_i;
            count_o     <= 16'd0;
            err_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready_o <= 1'b0;
                    imem_we_o   <= 1'b0;
                end
                READY: begin
                    if (req_valid_i) begin
                        if (illegal) begin
                            err_o <= 1'b1;
                        end else begin
                            imem_wdata_o <= enc_word;
                            imem_we_o    <= 1'b1;
                            req_ready_o  <= 1'b0;
                            state        <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (imem_ack_i) begin
                        imem_addr_o <= imem_addr_o + 32'd4;
                        if (count_o != 16'hFFFF) begin
                            count_o <= count_o + 16'd1;
                        end
                        imem_we_o   <= 1'b0;
                        req_ready_o <= 1'b1;
                        state       <= READY;
                    end
                end
                default: begin
                    state       <= IDLE;
                    req_ready_o <= 1'b0;
                    imem_we_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// tb_instr_encoder : scoreboard bench for instr_encoder
// Revision 1.0
// ============================================================================
module tb_instr_encoder;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  kind_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [4:0]  rd_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [31:0] imm_i;
    logic        imem_we_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_wdata_o;
    logic        imem_ack_i;
    logic [15:0] count_o;
    logic        err_o;

    always #5 clk_i = ~clk_i;

    instr_encoder dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .kind_i       (kind_i),
        .funct3_i     (funct3_i),
        .funct7_i     (funct7_i),
        .rd_i         (rd_i),
        .rs1_i        (rs1_i),
        .rs2_i        (rs2_i),
        .imm_i        (imm_i),
        .imem_we_o    (imem_we_o),
        .imem_addr_o  (imem_addr_o),
        .imem_wdata_o (imem_wdata_o),
        .imem_ack_i   (imem_ack_i),
        .count_o      (count_o),
        .err_o        (err_o)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] exp_addr;
    int          checks   = 0;
    int          failures = 0;
    int          nwrites  = 0;
    bit          auto_ack = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: acknowledges a pending write shortly after each rising edge.
    always @(posedge clk_i) begin
        #2;
        imem_ack_i = auto_ack && imem_we_o;
    end

    // Monitor: a completed write is we && ack seen mid-cycle.
    always @(negedge clk_i) begin
        if (rst_ni && imem_we_o && imem_ack_i) begin
            exp_t e;
            nwrites++;
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got %h @%h expected none", imem_wdata_o, imem_addr_o);
            end else begin
                e = sbq.pop_front();
                chk("wr_addr", imem_addr_o, e.a);
                chk("wr_data", imem_wdata_o, e.d);
            end
        end
    end

    task automatic do_start(input logic [31:0] base);
        @(negedge clk_i);
        sbq.delete();
        start_i     = 1'b1;
        base_addr_i = base;
        @(posedge clk_i);
        #1;
        start_i  = 1'b0;
        exp_addr = base;
        chk("start_ready", {31'd0, req_ready_o}, 32'd1);
        chk("start_we", {31'd0, imem_we_o}, 32'd0);
        chk("start_count", {16'd0, count_o}, 32'd0);
        chk("start_err", {31'd0, err_o}, 32'd0);
        chk("start_addr", imem_addr_o, base);
    endtask

    task automatic send(input logic [2:0] k, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input bit legal, input logic [31:0] word);
        int n = 0;
        @(negedge clk_i);
        while (!req_ready_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (!req_ready_o) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: got ready=0 expected ready=1");
            return;
        end
        kind_i   = k;
        funct3_i = f3;
        funct7_i = f7;
        rd_i     = rd;
        rs1_i    = rs1;
        rs2_i    = rs2;
        imm_i    = imm;
        if (legal) begin
            sbq.push_back({exp_addr, word});
            exp_addr = exp_addr + 32'd4;
        end
        req_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        chk("drain_pending", sbq.size(), 32'd0);
        @(negedge clk_i);
    endtask

    task automatic wait_we();
        int n = 0;
        @(negedge clk_i);
        while (!imem_we_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        chk("we_seen", {31'd0, imem_we_o}, 32'd1);
    endtask

    logic [31:0] held_a, held_d;
    int          w0;
    logic [15:0] c0;

    initial begin
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        base_addr_i = 32'd0;
        req_valid_i = 1'b0;
        kind_i      = 3'd0;
        funct3_i    = 3'd0;
        funct7_i    = 7'd0;
        rd_i        = 5'd0;
        rs1_i       = 5'd0;
        rs2_i       = 5'd0;
        imm_i       = 32'd0;
        imem_ack_i  = 1'b0;
        exp_addr    = 32'd0;
        #12 rst_ni  = 1'b1;

        @(negedge clk_i);
        chk("rst_ready", {31'd0, req_ready_o}, 32'd0);
        chk("rst_we", {31'd0, imem_we_o}, 32'd0);
        chk("rst_addr", imem_addr_o, 32'd0);
        chk("rst_wdata", imem_wdata_o, 32'd0);
        chk("rst_count", {16'd0, count_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        repeat (3) @(negedge clk_i);
        chk("idle_hold_ready", {31'd0, req_ready_o}, 32'd0);

        // Basic encodes
        do_start(32'h0000_0100);
        send(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h0050_0093);
        send(3'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h0020_81B3);
        drain();
        chk("count_basic", {16'd0, count_o}, 32'd2);

        // Store / branch / jump / upper
        send(3'd3, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 32'h0020_A423);
        send(3'd4, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b1, 32'hFE20_8EE3);
        send(3'd5, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1, 32'h0080_00EF);
        send(3'd7, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 32'h1234_52B7);
        drain();
        chk("count_mixed", {16'd0, count_o}, 32'd6);

        // Backpressure: ack withheld for five cycles
        auto_ack = 1'b0;
        send(3'd7, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 32'h1234_52B7);
        wait_we();
        held_a = imem_addr_o;
        held_d = imem_wdata_o;
        chk("bp_addr_value", held_a, 32'h0000_0118);
        w0 = nwrites;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("bp_addr_stable", imem_addr_o, held_a);
            chk("bp_data_stable", imem_wdata_o, held_d);
            chk("bp_ready_low", {31'd0, req_ready_o}, 32'd0);
            chk("bp_we_high", {31'd0, imem_we_o}, 32'd1);
        end
        auto_ack = 1'b1;
        drain();
        repeat (3) @(negedge clk_i);
        chk("bp_single_write", nwrites, w0 + 1);
        chk("count_bp", {16'd0, count_o}, 32'd7);

        // Illegal requests are consumed without writing
        w0 = nwrites;
        c0 = count_o;
        send(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 32'd0);
        send(3'd4, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, 32'd0);
        repeat (3) @(negedge clk_i);
        chk("ill_err", {31'd0, err_o}, 32'd1);
        chk("ill_nowrite", nwrites, w0);
        chk("ill_count", {16'd0, count_o}, {16'd0, c0});
        chk("ill_ready", {31'd0, req_ready_o}, 32'd1);
        send(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 1'b1, 32'h8000_0093);
        drain();
        chk("ill_err_sticky", {31'd0, err_o}, 32'd1);

        // Abort an in-flight write with start_i
        auto_ack = 1'b0;
        send(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h0050_0093);
        wait_we();
        do_start(32'h0000_0200);
        auto_ack = 1'b1;
        send(3'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h0020_81B3);
        drain();

        // Asynchronous reset mid-write
        auto_ack = 1'b0;
        send(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h0050_0093);
        wait_we();
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_we", {31'd0, imem_we_o}, 32'd0);
        chk("arst_ready", {31'd0, req_ready_o}, 32'd0);
        chk("arst_addr", imem_addr_o, 32'd0);
        chk("arst_wdata", imem_wdata_o, 32'd0);
        chk("arst_count", {16'd0, count_o}, 32'd0);
        chk("arst_err", {31'd0, err_o}, 32'd0);
        sbq.delete();
        auto_ack = 1'b1;
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("arst_idle", {31'd0, req_ready_o}, 32'd0);

        // Address wrap
        do_start(32'hFFFF_FFFC);
        sbq.push_back({32'hFFFF_FFFC, 32'h0050_0093});
        send(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'd0);
        sbq.push_back({32'h0000_0000, 32'h0020_81B3});
        send(3'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'd0);
        drain();
        chk("wrap_addr_next", imem_addr_o, 32'h0000_0004);
        chk("count_wrap", {16'd0, count_o}, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
